// File: rtl/ups_pkg.sv
// Shared types and constants for the DAC write-port scheduler and its neighbours.
package ups_pkg;

  typedef enum logic [1:0] {
    SCH_IDLE  = 2'd0,
    SCH_ISSUE = 2'd1,
    SCH_WAIT  = 2'd2
  } sched_state_t;

  localparam int UPS_DA_WORD_W = 16;

  // 16 bits at clk/8 is 128 cycles; the rest covers the CS setup/hold and LDAC phases.
  localparam int UPS_DA_FRAME_CYCLES = 192;

  function automatic logic [UPS_DA_WORD_W-1:0] clamp_code(
    input logic [UPS_DA_WORD_W-1:0] code,
    input logic [UPS_DA_WORD_W-1:0] lo,
    input logic [UPS_DA_WORD_W-1:0] hi
  );
    if (code < lo) return lo;
    if (code > hi) return hi;
    return code;
  endfunction

endpackage

// File: rtl/ups_rr_arb.sv
// Combinational round-robin arbiter: first asserted request at or after ptr, wrapping.
module ups_rr_arb #(
  parameter int N_REQ = 4,
  parameter int IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic             gnt_valid,
  output logic [IDX_W-1:0] gnt_idx
);

  // Scan from the farthest offset down so the nearest candidate to ptr wins last.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      int pos;
      pos = int'(ptr) + k;
      if (pos >= N_REQ) pos = pos - N_REQ;
      if (req[pos[IDX_W-1:0]]) begin
        gnt_valid = 1'b1;
        gnt_idx   = pos[IDX_W-1:0];
      end
    end
  end

endmodule

// File: rtl/ups_da_sched.sv
// Round-robin sharing of the single DAC write port, with code clamping and a
// fixed hold-off after every write because the port has no ready handshake.
//
// state     | meaning
// SCH_IDLE  | waiting for any request; grant and latch the clamped code
// SCH_ISSUE | da_dv/ack pulse out, advance ptr, load hold-off counter
// SCH_WAIT  | DAC frame in progress; requests ignored until counter hits 0
module ups_da_sched
  import ups_pkg::*;
#(
  parameter int                         N_REQ          = 4,
  parameter int                         HOLDOFF_CYCLES = UPS_DA_FRAME_CYCLES,
  parameter logic [UPS_DA_WORD_W-1:0]   CODE_MIN       = 16'h0000,
  parameter logic [UPS_DA_WORD_W-1:0]   CODE_MAX       = 16'hFFFF
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [N_REQ-1:0]                 req,
  input  logic [UPS_DA_WORD_W*N_REQ-1:0]   req_data,
  output logic [N_REQ-1:0]                 ack,
  output logic                             da_dv,
  output logic [UPS_DA_WORD_W-1:0]         da_data,
  output logic                             busy,
  output logic [$clog2(N_REQ)-1:0]         last_src,
  output logic                             clamp_hit
);

  localparam int IDX_W = $clog2(N_REQ);
  localparam int CNT_W = $clog2(HOLDOFF_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(HOLDOFF_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_REQ - 1);

  if (N_REQ < 2 || N_REQ > 8) begin : g_bad_nreq
    $error("ups_da_sched: N_REQ must be 2..8");
  end
  if (HOLDOFF_CYCLES < UPS_DA_FRAME_CYCLES) begin : g_bad_holdoff
    $error("ups_da_sched: HOLDOFF_CYCLES shorter than a DAC frame");
  end
  if (CODE_MIN > CODE_MAX) begin : g_bad_window
    $error("ups_da_sched: CODE_MIN above CODE_MAX");
  end

  sched_state_t              state, state_nxt;
  logic [IDX_W-1:0]          ptr;
  logic [CNT_W-1:0]          cnt;
  logic                      gnt_valid;
  logic [IDX_W-1:0]          gnt_idx;
  logic                      grant;
  logic [UPS_DA_WORD_W-1:0]  raw_code;
  logic [UPS_DA_WORD_W-1:0]  clamped;

  ups_rr_arb #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_arb (
    .req       (req),
    .ptr       (ptr),
    .gnt_valid (gnt_valid),
    .gnt_idx   (gnt_idx)
  );

  always_comb begin
    raw_code = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (gnt_idx == IDX_W'(k)) raw_code = req_data[UPS_DA_WORD_W*k +: UPS_DA_WORD_W];
    end
  end

  assign clamped = clamp_code(raw_code, CODE_MIN, CODE_MAX);

  always_comb begin
    state_nxt = state;
    grant     = 1'b0;
    case (state)
      SCH_IDLE: begin
        if (gnt_valid) begin
          grant     = 1'b1;
          state_nxt = SCH_ISSUE;
        end
      end
      SCH_ISSUE: state_nxt = SCH_WAIT;
      SCH_WAIT: begin
        if (cnt == '0) state_nxt = SCH_IDLE;
      end
      default: state_nxt = SCH_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= SCH_IDLE;
    else        state <= state_nxt;
  end

  // Strobes are registered at the grant edge so they land in the SCH_ISSUE cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack       <= '0;
      da_dv     <= 1'b0;
      da_data   <= '0;
      last_src  <= '0;
      clamp_hit <= 1'b0;
      ptr       <= '0;
      cnt       <= '0;
    end else begin
      ack       <= '0;
      da_dv     <= grant;
      clamp_hit <= grant && (clamped != raw_code);
      if (grant) begin
        ack[gnt_idx] <= 1'b1;
        da_data      <= clamped;
        last_src     <= gnt_idx;
      end
      if (state == SCH_ISSUE) begin
        ptr <= (last_src == IDX_LAST) ? '0 : last_src + 1'b1;
        cnt <= CNT_LOAD;
      end else if (state == SCH_WAIT && cnt != '0) begin
        cnt <= cnt - 1'b1;
      end
    end
  end

  assign busy = (state != SCH_IDLE);

endmodule

// File: doc/ups_da_sched.md
# ups_da_sched

Round-robin scheduler that shares the single DAC write port (`ups_da`, AD5541A) among up to N_REQ requesters (e.g. output setpoint, trim loop, self-test, host override). Each requester presents a 16-bit code with a level request and receives a one-cycle acknowledge when the code is issued. The block clamps each code to a safe window, issues a one-cycle `dv` strobe, then holds off for a fixed frame time, because the DAC port has no ready signal and ignores `dv` while a frame is in progress.

## Interface
- N_REQ, 4: number of requesters, 2..8.
- HOLDOFF_CYCLES, 192: clk cycles blocked after each `da_dv`. Must be ≥1 and ≥ the worst-case DAC frame length (16 bits at sclk = clk/8, plus CS and LDAC phases).
- CODE_MIN, 16'h0000: lowest code allowed to reach the DAC.
- CODE_MAX, 16'hFFFF: highest code allowed to reach the DAC. CODE_MIN ≤ CODE_MAX.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous, active-low reset.
- req  in  N_REQ  per-requester level request.
- req_data  in  16*N_REQ  codes; requester i uses bits [16i+15:16i].
- ack  out  N_REQ  one-cycle pulse to the granted requester.
- da_dv  out  1  one-cycle write strobe to the DAC port.
- da_data  out  16  clamped code; valid while `da_dv`=1 and held until the next issue.
- busy  out  1  high whenever the state is not SCH_IDLE.
- last_src  out  $clog2(N_REQ)  index of the most recently granted requester.
- clamp_hit  out  1  one-cycle pulse, coincident with `da_dv`, when the issued code was clamped.

## Operation
- States are SCH_IDLE, SCH_ISSUE and SCH_WAIT.
- **SCH_IDLE:** if any `req` bit is high, grant round-robin, starting the search at `ptr`.
  - Latch the clamped `req_data` and the granted index.
  - Go to SCH_ISSUE.
- **SCH_ISSUE:** for one cycle, drive `da_dv`=1, `ack[src]`=1 and `clamp_hit` if applicable.
  - Set `ptr` to (src+1) mod N_REQ.
  - Load the hold-off counter with HOLDOFF_CYCLES−1.
  - Go to SCH_WAIT.
- **SCH_WAIT:** decrement the counter. When the counter equals 0, go to SCH_IDLE. Requests are ignored in this state.
- **Clamp:** an unsigned compare produces max(CODE_MIN, min(code, CODE_MAX)). `clamp_hit` = (clamped ≠ raw).
- **Requester rule:** hold `req` high with stable data until `ack`. The code is captured in the SCH_IDLE grant cycle, so a data change after that cycle is not issued. Dropping `req` before it is granted withdraws it and produces no `ack`.
- **Simultaneous requests:** resolved purely by `ptr`. A requester holding `req` continuously is served at least once every N_REQ grants.
- **ptr wrap:** index N_REQ−1 wraps to 0. With a non-power-of-2 N_REQ, an out-of-range `ptr` never occurs.
- **Reset values:**
  - `ack`=0, `da_dv`=0, `da_data`=0, `busy`=0, `last_src`=0, `clamp_hit`=0.
  - `ptr`=0, counter=0, state=SCH_IDLE.
- **Reset mid-operation:** everything returns to SCH_IDLE immediately (asynchronous reset). `ups_da` shares `rst_n`, so any partial SPI frame is abandoned. No `ack` is generated for the interrupted grant.

## Timing
- All outputs are registered. There is no combinational path from `req` to any output.
- Latency: `req` high in cycle t while in SCH_IDLE gives `da_dv`/`ack` in t+1.
- `busy` rises in t+1 and stays high through SCH_ISSUE and SCH_WAIT.
- Issue-to-issue spacing is HOLDOFF_CYCLES+2 cycles minimum: ISSUE, then HOLDOFF_CYCLES in WAIT, then one IDLE sample.
- `da_dv` is never high in two cycles closer together than that spacing.
- A request arriving during SCH_WAIT is granted in the SCH_IDLE cycle that follows.

## Structure
- Shared package `ups_pkg` holds:
  - the `sched_state_t` enum;
  - `UPS_DA_WORD_W`=16;
  - `UPS_DA_FRAME_CYCLES`, used as the default and minimum for HOLDOFF_CYCLES.
- Sub-module `ups_rr_arb` is combinational:
  - inputs: `req`, `ptr`;
  - outputs: `gnt_valid`, `gnt_idx`.
- `ups_da_sched` instantiates `ups_rr_arb` and contains the FSM, clamp and counter. `ups_da` is instantiated beside it at the top level, not inside.

## Test plan
- **Single requester:** req[2]=1 with code 16'h1234 → `da_dv` and `ack[2]` one cycle later, `da_data`=1234, `last_src`=2, `clamp_hit`=0.
- **All four requesting from reset:** grants in order 0,1,2,3,0; `da_dv` spacing exactly HOLDOFF_CYCLES+2 cycles.
- **Clamp:** CODE_MIN=16'h0100, CODE_MAX=16'hF000.
  - Code 16'h0010 → `da_data`=0100, `clamp_hit`=1.
  - Code FFFF → F000, `clamp_hit`=1.
  - Code 8000 → 8000, `clamp_hit`=0.
- **Request during SCH_WAIT:** req[1] asserted mid-hold-off → no `da_dv` until the counter expires; then grant in the next SCH_IDLE.
- **Withdrawal:** req[3] pulsed for 2 cycles, both inside SCH_WAIT → never acked, and no `da_dv` for it.
- **Reset mid-WAIT:** `rst_n` low for 1 cycle → outputs zero immediately, `busy`=0, `ptr`=0; the next request is granted with normal one-cycle latency.
